// File: rtl/neur_event_sequencer.sv
// -----------------------------------------------------------------------------
// neur_event_sequencer
//
// Purpose:
//   Turns each AER input event into a full sweep over all N post-synaptic
//   neurons. Every post index gets one SRAM read cycle followed by one
//   write-back cycle on the neuron SRAM. For synaptic events the synapse SRAM
//   is accessed in step, and CTRL_NEUR_EVENT is strobed. For time-reference
//   events the synapse SRAM is left idle and CTRL_NEUR_TREF is strobed. The
//   AER handshake is closed with a 4-phase acknowledge once the sweep is done.
//
// Ports:
//   CLK                     in   system clock, rising edge
//   RSTN_syncn              in   asynchronous active-low reset
//   SPI_GATE_ACTIVITY_sync  in   SPI owns the SRAMs; blocks new events only
//   AERIN_REQ               in   AER request (already synchronous to CLK)
//   AERIN_ADDR[2M:0]        in   [2M] event type (1 = time ref), [M-1:0] pre
//   AERIN_ACK               out  AER acknowledge
//   CTRL_NEUR_EVENT         out  synaptic-event strobe to neuron_core
//   CTRL_NEUR_TREF          out  time-reference strobe to neuron_core
//   CTRL_NEURMEM_CS/WE      out  neuron SRAM chip select / write enable
//   CTRL_NEURMEM_ADDR[M-1:0]      neuron SRAM address (post index)
//   CTRL_SYNARRAY_CS/WE     out  synapse SRAM chip select / write enable
//   CTRL_SYNARRAY_ADDR[2M-4:0]    synapse SRAM address {pre, post[M-1:3]}
//   CTRL_NEUR_BURST_END     out  pulse on the last write-back of a sweep
//   CTRL_BUSY               out  high while a sweep is in progress
// -----------------------------------------------------------------------------
module neur_event_sequencer #(
  parameter int N = 256,
  parameter int M = 8
) (
  input  logic             CLK,
  input  logic             RSTN_syncn,
  input  logic             SPI_GATE_ACTIVITY_sync,
  input  logic             AERIN_REQ,
  input  logic [2*M:0]     AERIN_ADDR,
  output logic             AERIN_ACK,
  output logic             CTRL_NEUR_EVENT,
  output logic             CTRL_NEUR_TREF,
  output logic             CTRL_NEURMEM_CS,
  output logic             CTRL_NEURMEM_WE,
  output logic [M-1:0]     CTRL_NEURMEM_ADDR,
  output logic             CTRL_SYNARRAY_CS,
  output logic             CTRL_SYNARRAY_WE,
  output logic [2*M-4:0]   CTRL_SYNARRAY_ADDR,
  output logic             CTRL_NEUR_BURST_END,
  output logic             CTRL_BUSY
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  state_t       r_state;
  state_t       w_state_next;

  logic [M-1:0] r_post;     // post-synaptic neuron currently swept
  logic [M-1:0] r_pre;      // latched pre-synaptic neuron
  logic         r_tref;     // latched event type: 1 = time reference

  logic         w_accept;
  logic         w_last_post;
  logic         w_sweep;
  logic         w_addr_unused;

  // Address bits between the type flag and the pre index carry no meaning here.
  assign w_addr_unused = ^AERIN_ADDR[2*M-1:M];

  // A new event is taken only from IDLE, with the handshake low and the SPI
  // not holding the SRAMs. Since IDLE is only reached after REQ has been seen
  // low in ACK, a REQ still high from the previous event cannot re-trigger.
  assign w_accept    = (r_state == S_IDLE) && AERIN_REQ && !AERIN_ACK &&
                       !SPI_GATE_ACTIVITY_sync;
  assign w_last_post = (r_post == M'(N - 1));
  assign w_sweep     = (r_state == S_READ) || (r_state == S_WRITE);

  // State register
  always_ff @(posedge CLK or negedge RSTN_syncn) begin
    if (!RSTN_syncn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Event latch and post counter. The counter is cleared on acceptance and
  // otherwise only advances on a write-back that is not the last one, so it
  // never rolls over inside a sweep and parks at N-1 afterwards.
  always_ff @(posedge CLK or negedge RSTN_syncn) begin
    if (!RSTN_syncn) begin
      r_post <= '0;
      r_pre  <= '0;
      r_tref <= 1'b0;
    end else if (w_accept) begin
      r_post <= '0;
      r_pre  <= AERIN_ADDR[M-1:0];
      r_tref <= AERIN_ADDR[2*M];
    end else if ((r_state == S_WRITE) && !w_last_post) begin
      r_post <= r_post + 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_READ;
      S_READ:  w_state_next = S_WRITE;
      S_WRITE: w_state_next = w_last_post ? S_ACK : S_READ;
      S_ACK:   if (!AERIN_REQ) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs decode from registered state only, so the async reset forces
  // them low immediately and the acknowledge is glitch-free.
  always_comb begin
    AERIN_ACK           = (r_state == S_ACK);
    CTRL_BUSY           = w_sweep;
    CTRL_NEURMEM_CS     = w_sweep;
    CTRL_NEURMEM_WE     = (r_state == S_WRITE);
    CTRL_NEUR_EVENT     = w_sweep && !r_tref;
    CTRL_NEUR_TREF      = w_sweep && r_tref;
    CTRL_SYNARRAY_CS    = w_sweep && !r_tref;
    CTRL_SYNARRAY_WE    = (r_state == S_WRITE) && !r_tref;
    CTRL_NEUR_BURST_END = (r_state == S_WRITE) && w_last_post;
    // Addresses follow the registers, so they hold outside a sweep.
    CTRL_NEURMEM_ADDR   = r_post;
    CTRL_SYNARRAY_ADDR  = '0;
    if (!r_tref) begin
      // Eight consecutive post neurons share one synapse SRAM word.
      CTRL_SYNARRAY_ADDR = {r_pre, r_post[M-1:3]};
    end
  end

endmodule

// File: tb/tb_neur_event_sequencer.sv
module tb_neur_event_sequencer;

  localparam int N = 256;
  localparam int M = 8;

  logic            CLK = 1'b0;
  logic            RSTN_syncn = 1'b0;
  logic            SPI_GATE_ACTIVITY_sync = 1'b0;
  logic            AERIN_REQ = 1'b0;
  logic [2*M:0]    AERIN_ADDR = '0;
  logic            AERIN_ACK;
  logic            CTRL_NEUR_EVENT;
  logic            CTRL_NEUR_TREF;
  logic            CTRL_NEURMEM_CS;
  logic            CTRL_NEURMEM_WE;
  logic [M-1:0]    CTRL_NEURMEM_ADDR;
  logic            CTRL_SYNARRAY_CS;
  logic            CTRL_SYNARRAY_WE;
  logic [2*M-4:0]  CTRL_SYNARRAY_ADDR;
  logic            CTRL_NEUR_BURST_END;
  logic            CTRL_BUSY;

  neur_event_sequencer #(.N(N), .M(M)) dut (
    .CLK                    (CLK),
    .RSTN_syncn             (RSTN_syncn),
    .SPI_GATE_ACTIVITY_sync (SPI_GATE_ACTIVITY_sync),
    .AERIN_REQ              (AERIN_REQ),
    .AERIN_ADDR             (AERIN_ADDR),
    .AERIN_ACK              (AERIN_ACK),
    .CTRL_NEUR_EVENT        (CTRL_NEUR_EVENT),
    .CTRL_NEUR_TREF         (CTRL_NEUR_TREF),
    .CTRL_NEURMEM_CS        (CTRL_NEURMEM_CS),
    .CTRL_NEURMEM_WE        (CTRL_NEURMEM_WE),
    .CTRL_NEURMEM_ADDR      (CTRL_NEURMEM_ADDR),
    .CTRL_SYNARRAY_CS       (CTRL_SYNARRAY_CS),
    .CTRL_SYNARRAY_WE       (CTRL_SYNARRAY_WE),
    .CTRL_SYNARRAY_ADDR     (CTRL_SYNARRAY_ADDR),
    .CTRL_NEUR_BURST_END    (CTRL_NEUR_BURST_END),
    .CTRL_BUSY              (CTRL_BUSY)
  );

  always #5 CLK = ~CLK;

  // Edge counter: at a negedge, cyc equals the number of rising edges so far.
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Expected access: {we, naddr[7:0], syn_cs, syn_we, syn_addr[12:0],
  //                   event, tref, burst_end, busy, neur_cs}
  typedef struct {
    int          cyc;
    logic [28:0] vec;
  } access_t;

  access_t exp_q[$];
  int      ack_rise_q[$];
  int      ack_fall_q[$];

  int checks = 0;
  int failures = 0;
  int last_t = 0;

  task automatic report_fail(input string name, input longint got, input longint req);
    failures++;
    $display("FAIL %s at cyc=%0d: got=%0h required=%0h", name, cyc, got, req);
  endtask

  // Expected sweep for an event whose REQ is sampled at rising edge t:
  // access i is presented after edge t+i; ACK appears after edge t+2N.
  task automatic push_event(input logic [2*M:0] a, input int t);
    int          post;
    logic        we, tref;
    logic [12:0] sa;
    int          pre;
    access_t     e;
    tref = a[2*M];
    pre  = int'(a[7:0]);
    for (int i = 0; i < 2*N; i++) begin
      post = i / 2;
      we   = (i % 2) == 1;
      sa   = tref ? 13'd0 : 13'(pre * 32 + post / 8);
      e.cyc = t + i;
      e.vec = {we, 8'(post), !tref, (!tref && we), sa, !tref, tref,
               (we && post == N-1), 1'b1, 1'b1};
      exp_q.push_back(e);
    end
    ack_rise_q.push_back(t + 2*N);
    last_t = t;
  endtask

  // Monitor / scoreboard
  logic        prev_ack = 1'b0;
  logic [28:0] act;
  access_t     got_e;

  always @(negedge CLK) begin
    act = {CTRL_NEURMEM_WE, CTRL_NEURMEM_ADDR, CTRL_SYNARRAY_CS, CTRL_SYNARRAY_WE,
           CTRL_SYNARRAY_ADDR, CTRL_NEUR_EVENT, CTRL_NEUR_TREF, CTRL_NEUR_BURST_END,
           CTRL_BUSY, CTRL_NEURMEM_CS};
    checks++;
    if (CTRL_NEURMEM_CS) begin
      if (exp_q.size() == 0) begin
        report_fail("unexpected_access", longint'(act), 0);
      end else begin
        got_e = exp_q.pop_front();
        if (got_e.cyc != cyc) report_fail("access_cycle", cyc, got_e.cyc);
        else if (got_e.vec != act) report_fail("access_fields", longint'(act), longint'(got_e.vec));
      end
    end else begin
      if ({CTRL_NEUR_EVENT, CTRL_NEUR_TREF, CTRL_NEURMEM_WE, CTRL_SYNARRAY_CS,
           CTRL_SYNARRAY_WE, CTRL_NEUR_BURST_END, CTRL_BUSY} != 7'd0)
        report_fail("idle_strobes", longint'(act), 0);
    end
    if (AERIN_ACK && !prev_ack) begin
      checks++;
      if (ack_rise_q.size() == 0) report_fail("unexpected_ack_rise", cyc, 0);
      else begin
        int exp_c;
        exp_c = ack_rise_q.pop_front();
        if (exp_c != cyc) report_fail("ack_rise_cycle", cyc, exp_c);
      end
      $display("TXN ack rise at cyc=%0d", cyc);
    end
    if (!AERIN_ACK && prev_ack) begin
      checks++;
      if (ack_fall_q.size() == 0) report_fail("unexpected_ack_fall", cyc, 0);
      else begin
        int exp_c;
        exp_c = ack_fall_q.pop_front();
        if (exp_c != cyc) report_fail("ack_fall_cycle", cyc, exp_c);
      end
    end
    prev_ack = AERIN_ACK;
  end

  function automatic logic [29:0] all_outputs();
    return {AERIN_ACK, CTRL_NEUR_EVENT, CTRL_NEUR_TREF, CTRL_NEURMEM_CS,
            CTRL_NEURMEM_WE, CTRL_NEURMEM_ADDR, CTRL_SYNARRAY_CS, CTRL_SYNARRAY_WE,
            CTRL_SYNARRAY_ADDR, CTRL_NEUR_BURST_END, CTRL_BUSY};
  endfunction

  task automatic issue(input logic [2*M:0] a);
    @(negedge CLK); #1;
    AERIN_ADDR = a;
    AERIN_REQ  = 1'b1;
    push_event(a, cyc + 1);
  endtask

  task automatic release_req();
    @(negedge CLK); #1;
    AERIN_REQ = 1'b0;
    ack_fall_q.push_back(cyc + 1);
  endtask

  task automatic wait_ack(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge CLK);
      if (AERIN_ACK) seen = 1;
    end
    checks++;
    if (!seen) report_fail("ack_timeout", 0, 1);
  endtask

  // Returns at the negedge where the READ of post index n is presented.
  task automatic wait_post(input int n);
    bit seen = 0;
    for (int i = 0; i < 2*N + 10 && !seen; i++) begin
      @(negedge CLK);
      if (CTRL_NEURMEM_CS && !CTRL_NEURMEM_WE && CTRL_NEURMEM_ADDR == 8'(n)) seen = 1;
    end
    checks++;
    if (!seen) report_fail("post_timeout", 0, n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. Reset held with REQ high, then released while gated.
    AERIN_REQ = 1'b1;
    repeat (3) @(negedge CLK);
    #1;
    checks++;
    if (all_outputs() != 30'd0) report_fail("reset_outputs", longint'(all_outputs()), 0);
    SPI_GATE_ACTIVITY_sync = 1'b1;
    #1 RSTN_syncn = 1'b1;
    repeat (1000) @(negedge CLK);
    #1;
    AERIN_REQ = 1'b0;
    SPI_GATE_ACTIVITY_sync = 1'b0;
    repeat (3) @(negedge CLK);

    // 2. Synaptic event, pre = 5: synapse words 0x0A0..0x0BF.
    issue(17'h00005);
    wait_ack(2*N + 10);
    release_req();
    repeat (5) @(negedge CLK);

    // 3. Time-ref event; REQ drops and ADDR changes mid-sweep -> ACK pulses one cycle.
    issue(17'h10000);
    wait_post(10);
    #1;
    AERIN_REQ  = 1'b0;
    AERIN_ADDR = 17'h1FFFF;
    ack_fall_q.push_back(last_t + 2*N + 1);
    wait_ack(2*N + 10);
    repeat (5) @(negedge CLK);

    // 4. REQ held 20 cycles past ACK; middle address bits are ignored (pre = 0x12).
    issue(17'h0AB12);
    wait_ack(2*N + 10);
    repeat (20) @(negedge CLK);
    release_req();
    repeat (30) @(negedge CLK);

    // 5. Gate rises at post 100: sweep completes; next REQ waits for gate low.
    issue(17'h0003C);
    wait_post(100);
    #1 SPI_GATE_ACTIVITY_sync = 1'b1;
    wait_ack(2*N + 10);
    release_req();
    repeat (5) @(negedge CLK);
    #1;
    AERIN_ADDR = 17'h000FF;
    AERIN_REQ  = 1'b1;
    repeat (50) @(negedge CLK);
    checks++;
    if (AERIN_ACK !== 1'b0 || CTRL_BUSY !== 1'b0)
      report_fail("gated_req", {AERIN_ACK, CTRL_BUSY}, 0);
    #1;
    SPI_GATE_ACTIVITY_sync = 1'b0;
    push_event(17'h000FF, cyc + 1);
    wait_ack(2*N + 10);
    release_req();
    repeat (5) @(negedge CLK);

    // 6. Reset at post 40: outputs drop at once, event lost, then a clean restart.
    issue(17'h00007);
    wait_post(40);
    #1 RSTN_syncn = 1'b0;
    #1;
    checks++;
    if (all_outputs() != 30'd0) report_fail("midsweep_reset_outputs", longint'(all_outputs()), 0);
    exp_q.delete();
    ack_rise_q.delete();
    AERIN_REQ = 1'b0;
    @(negedge CLK);
    #1 RSTN_syncn = 1'b1;
    repeat (5) @(negedge CLK);
    issue(17'h00009);
    wait_ack(2*N + 10);
    release_req();
    repeat (10) @(negedge CLK);

    checks++;
    if (exp_q.size() != 0) report_fail("leftover_accesses", exp_q.size(), 0);
    checks++;
    if (ack_rise_q.size() != 0) report_fail("leftover_ack_rise", ack_rise_q.size(), 0);
    checks++;
    if (ack_fall_q.size() != 0) report_fail("leftover_ack_fall", ack_fall_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
